// File: rtl/fp_normalize_if.sv
`timescale 1ns/1ps
// fp_normalize_if: start/busy/done handshake and operand/result bus for fp_normalize.
// Signals: norm_start/in_sign/in_exp/in_frac (request side), norm_result and
//          norm_busy/norm_done/norm_overflow/norm_underflow (response side).
// master = requester (add/sub stage or bench), slave = fp_normalize.
interface fp_normalize_if;
  logic        norm_start;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_frac;
  logic [31:0] norm_result;
  logic        norm_busy;
  logic        norm_done;
  logic        norm_overflow;
  logic        norm_underflow;

  modport master (
    output norm_start, in_sign, in_exp, in_frac,
    input  norm_result, norm_busy, norm_done, norm_overflow, norm_underflow
  );

  modport slave (
    input  norm_start, in_sign, in_exp, in_frac,
    output norm_result, norm_busy, norm_done, norm_overflow, norm_underflow
  );
endinterface

// File: rtl/fp_normalize.sv
`timescale 1ns/1ps
// fp_normalize: iterative post-add normalize, round-to-nearest-even and IEEE-754 single pack.
// Latency: done after edge 2+n (n = SHIFT-state shifts), zero input after edge 0; worst case 27.
// Backpressure: none; norm_start is only sampled in IDLE, ignored while busy (no queuing).
// Ports: clk, n_rst (async active-low), bus (fp_normalize_if.slave: start/operands in,
//        result/busy/done/overflow/underflow out).
// Build option: FP_NORM_DENORM_EN defined produces subnormal results at the exponent
//        floor; undefined flushes them to signed zero.
module fp_normalize (
  input  logic           clk,
  input  logic           n_rst,
  fp_normalize_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [26:0] sig_q, sig_d;      // [26] carry, [25] hidden, [24:2] frac, [1] guard, [0] sticky
  logic [8:0]  e_q, e_d;          // bit 8 catches carry past 255
  logic        sgn_q, sgn_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        round_up;
  logic [26:0] sig_rnd;
  logic [26:0] sig_fin;
  logic [8:0]  e_fin;
  logic [7:0]  exp_field;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      sig_q    <= '0;
      e_q      <= '0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      e_q      <= e_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    // Rounding datapath, only consumed in ROUND.
    round_up = sig_q[1] & (sig_q[0] | sig_q[2]);
    sig_rnd  = sig_q + (round_up ? 27'd4 : 27'd0);
    if (sig_rnd[26]) begin
      // Mantissa overflowed by rounding: renormalize right, keeping sticky.
      sig_fin = {1'b0, sig_rnd[26:2], sig_rnd[1] | sig_rnd[0]};
      e_fin   = e_q + 9'd1;
    end else begin
      sig_fin = sig_rnd;
      e_fin   = e_q;
    end
`ifdef FP_NORM_DENORM_EN
    // Entering ROUND without the hidden bit means we stopped at the exponent
    // floor: field is 0 (subnormal) unless rounding promoted it into the hidden bit.
    if (!sig_q[25]) begin
      exp_field = {7'd0, sig_fin[25]};
    end else begin
      exp_field = e_fin[7:0];
    end
`else
    exp_field = e_fin[7:0];
`endif

    state_d  = state_q;
    sig_d    = sig_q;
    e_d      = e_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.norm_start) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          if (bus.in_frac == 27'd0) begin
            result_d = {bus.in_sign, 31'd0};
            state_d  = S_DONE;
          end else begin
            sig_d   = bus.in_frac;
            e_d     = {1'b0, bus.in_exp};
            sgn_d   = bus.in_sign;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (sig_q[26]) begin
          sig_d = {1'b0, sig_q[26:2], sig_q[1] | sig_q[0]};
          e_d   = e_q + 9'd1;
        end else if (sig_q[25]) begin
          state_d = S_ROUND;
        end else if (e_q <= 9'd1) begin
`ifdef FP_NORM_DENORM_EN
          state_d = S_ROUND;
`else
          result_d = {sgn_q, 31'd0};
          unf_d    = 1'b1;
          state_d  = S_DONE;
`endif
        end else begin
          sig_d = {sig_q[25:0], 1'b0};
          e_d   = e_q - 9'd1;
        end
      end
      S_ROUND: begin
        sig_d = sig_fin;
        e_d   = e_fin;
        if (e_fin >= 9'd255) begin
          result_d = {sgn_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sgn_q, exp_field, sig_fin[24:2]};
`ifdef FP_NORM_DENORM_EN
          unf_d    = (exp_field == 8'd0);
`endif
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.norm_result    = result_q;
  assign bus.norm_busy      = (state_q != S_IDLE);
  assign bus.norm_done      = (state_q == S_DONE);
  assign bus.norm_overflow  = ovf_q;
  assign bus.norm_underflow = unf_q;

endmodule

// File: tb/tb_fp_normalize.sv
`timescale 1ns/1ps
// tb_fp_normalize: directed vector table, hand-written control sequences and
// randomized operands against an arithmetic reference model.
// Timing figure checked is the index of the clock edge (edge 0 samples start)
// after which norm_done is first seen high.
module tb_fp_normalize;

  logic clk;
  logic n_rst;
  int   errors;
  int   checks;

  fp_normalize_if bus();

  fp_normalize dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] frac;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          dedge;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Reference: value-level normalize/round straight from the rules, plain integers.
  function automatic void model(input logic s, input logic [7:0] ex, input logic [26:0] fr,
                                output logic [31:0] res, output logic ovf,
                                output logic unf, output int dedge);
    longint      sig;
    int          e;
    int          n;
    bit          denorm;
    int          field;
    logic [26:0] sg;
    logic [7:0]  fld8;
    sig = longint'(fr);
    e   = int'(ex);
    n   = 0;
    ovf = 1'b0;
    unf = 1'b0;
    if (fr == 27'd0) begin
      res   = {s, 31'd0};
      dedge = 0;
      return;
    end
    while (1) begin
      if (sig >= (64'sd1 << 26)) begin
        sig = (sig >> 1) | (sig & 1);
        e   = e + 1;
        n++;
      end else if (sig >= (64'sd1 << 25)) begin
        break;
      end else if (e <= 1) begin
`ifdef FP_NORM_DENORM_EN
        break;
`else
        // Flush: ROUND is skipped, so done comes one edge earlier.
        res   = {s, 31'd0};
        unf   = 1'b1;
        dedge = 1 + n;
        return;
`endif
      end else begin
        sig = sig * 2;
        e   = e - 1;
        n++;
      end
    end
    denorm = (sig < (64'sd1 << 25));
    if (((sig >> 1) & 1) == 1 && ((sig & 1) == 1 || ((sig >> 2) & 1) == 1))
      sig = sig + 4;
    if (sig >= (64'sd1 << 26)) begin
      sig = (sig >> 1) | (sig & 1);
      e   = e + 1;
    end
    dedge = 2 + n;
    if (e >= 255) begin
      res = {s, 8'hFF, 23'd0};
      ovf = 1'b1;
      return;
    end
    if (denorm) field = (sig >= (64'sd1 << 25)) ? 1 : 0;
    else        field = e;
    sg   = sig[26:0];
    fld8 = field[7:0];
    res  = {s, fld8, sg[24:2]};
`ifdef FP_NORM_DENORM_EN
    unf = (field == 0);
`endif
  endfunction

  function automatic vec_t mk(input logic s, input logic [7:0] ex, input logic [26:0] fr,
                              input logic [31:0] res, input logic ovf, input logic unf,
                              input int dedge);
    vec_t v;
    v.sign = s; v.exp = ex; v.frac = fr;
    v.res = res; v.ovf = ovf; v.unf = unf; v.dedge = dedge;
    return v;
  endfunction

  // Issue one operation; hold > 0 keeps norm_start high (with junk operands)
  // for that many further edges to show it is ignored while busy.
  task automatic run_op(input logic s, input logic [7:0] ex, input logic [26:0] fr,
                        input int hold, output logic [31:0] res, output logic ovf,
                        output logic unf, output int dedge);
    @(negedge clk);
    bus.norm_start = 1'b1;
    bus.in_sign    = s;
    bus.in_exp     = ex;
    bus.in_frac    = fr;
    @(posedge clk);
    dedge = -1;
    res   = '0;
    ovf   = 1'b0;
    unf   = 1'b0;
    for (int k = 0; k < 40 && dedge < 0; k++) begin
      @(negedge clk);
      if (k >= hold) begin
        bus.norm_start = 1'b0;
      end else begin
        bus.in_sign = ~s;
        bus.in_exp  = 8'd200;
        bus.in_frac = 27'd0;
      end
      if (k == 0) chk("busy_after_start", 32'(bus.norm_busy), 32'd1);
      if (bus.norm_done) begin
        dedge = k;
        res   = bus.norm_result;
        ovf   = bus.norm_overflow;
        unf   = bus.norm_underflow;
      end
    end
    bus.norm_start = 1'b0;
    if (dedge < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no norm_done within 40 edges, required one");
    end else begin
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.norm_done), 32'd0);
      chk("busy_falls", 32'(bus.norm_busy), 32'd0);
      chk("result_holds", bus.norm_result, res);
    end
  endtask

  logic [31:0] r_res, m_res;
  logic        r_ovf, r_unf, m_ovf, m_unf;
  int          r_edge, m_edge;
  int          done_seen;

  initial begin
    errors = 0;
    checks = 0;
    n_rst          = 1'b0;
    bus.norm_start = 1'b0;
    bus.in_sign    = 1'b0;
    bus.in_exp     = 8'd0;
    bus.in_frac    = 27'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_result", bus.norm_result, 32'd0);
    chk("rst_busy", 32'(bus.norm_busy), 32'd0);
    chk("rst_done", 32'(bus.norm_done), 32'd0);
    chk("rst_ovf", 32'(bus.norm_overflow), 32'd0);
    chk("rst_unf", 32'(bus.norm_underflow), 32'd0);
    n_rst = 1'b1;

    // Directed table: values worked out by hand from the IEEE encoding.
    vecs.push_back(mk(1'b0, 8'd127, 27'h5800000, 32'h40300000, 1'b0, 1'b0, 3));  // 1.25+1.50
    vecs.push_back(mk(1'b0, 8'd127, 27'h0800000, 32'h3E800000, 1'b0, 1'b0, 4));  // 1.50-1.25
    vecs.push_back(mk(1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b0, 2));  // round carry
    vecs.push_back(mk(1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 2));  // tie, even lsb
    vecs.push_back(mk(1'b0, 8'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 2));  // tie, odd lsb
    vecs.push_back(mk(1'b1, 8'd127, 27'h2000003, 32'hBF800001, 1'b0, 1'b0, 2));  // guard+sticky
    vecs.push_back(mk(1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 3));  // overflow
    vecs.push_back(mk(1'b1, 8'd255, 27'h2000000, 32'hFF800000, 1'b1, 1'b0, 2));  // exp 255 in
    vecs.push_back(mk(1'b1, 8'd0,   27'h0000000, 32'h80000000, 1'b0, 1'b0, 0));  // -zero
    vecs.push_back(mk(1'b0, 8'd127, 27'h0000001, 32'h33000000, 1'b0, 1'b0, 27)); // 25 left shifts
`ifdef FP_NORM_DENORM_EN
    vecs.push_back(mk(1'b0, 8'd1,   27'h1000000, 32'h00400000, 1'b0, 1'b1, 2));
    vecs.push_back(mk(1'b0, 8'd3,   27'h0400000, 32'h00400000, 1'b0, 1'b1, 4));
`else
    vecs.push_back(mk(1'b0, 8'd1,   27'h1000000, 32'h00000000, 1'b0, 1'b1, 1));
    vecs.push_back(mk(1'b1, 8'd3,   27'h0400000, 32'h80000000, 1'b0, 1'b1, 3));
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].sign, vecs[i].exp, vecs[i].frac, 0, r_res, r_ovf, r_unf, r_edge);
      chk($sformatf("vec%0d_result", i), r_res, vecs[i].res);
      chk($sformatf("vec%0d_ovf", i), 32'(r_ovf), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_unf", i), 32'(r_unf), 32'(vecs[i].unf));
      chk($sformatf("vec%0d_done_edge", i), 32'(r_edge), 32'(vecs[i].dedge));
    end

    // norm_start held through SHIFT with different operands must be ignored.
    run_op(1'b0, 8'd127, 27'h0800000, 2, r_res, r_ovf, r_unf, r_edge);
    chk("start_ignored_result", r_res, 32'h3E800000);
    chk("start_ignored_edge", 32'(r_edge), 32'd4);

    // Reset mid-SHIFT: outputs clear at once, no done pulse, then normal op.
    @(negedge clk);
    bus.norm_start = 1'b1;
    bus.in_sign    = 1'b1;
    bus.in_exp     = 8'd127;
    bus.in_frac    = 27'h0000001;
    @(negedge clk);
    bus.norm_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(bus.norm_busy), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("abort_result", bus.norm_result, 32'd0);
    chk("abort_busy", 32'(bus.norm_busy), 32'd0);
    chk("abort_done", 32'(bus.norm_done), 32'd0);
    chk("abort_ovf", 32'(bus.norm_overflow), 32'd0);
    chk("abort_unf", 32'(bus.norm_underflow), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (bus.norm_done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run_op(1'b0, 8'd127, 27'h5800000, 0, r_res, r_ovf, r_unf, r_edge);
    chk("after_abort_result", r_res, 32'h40300000);
    chk("after_abort_edge", 32'(r_edge), 32'd3);

    // Randomized operands with a random number of leading zeros.
    for (int i = 0; i < 200; i++) begin
      logic        s;
      logic [7:0]  ex;
      logic [26:0] fr;
      int          lz;
      s  = 1'($urandom_range(0, 1));
      ex = 8'($urandom_range(0, 255));
      lz = $urandom_range(0, 26);
      fr = 27'($urandom) >> lz;
      model(s, ex, fr, m_res, m_ovf, m_unf, m_edge);
      run_op(s, ex, fr, 0, r_res, r_ovf, r_unf, r_edge);
      chk($sformatf("rnd%0d_result(e=%0d f=%h)", i, ex, fr), r_res, m_res);
      chk($sformatf("rnd%0d_ovf", i), 32'(r_ovf), 32'(m_ovf));
      chk($sformatf("rnd%0d_unf", i), 32'(r_unf), 32'(m_unf));
      chk($sformatf("rnd%0d_done_edge", i), 32'(r_edge), 32'(m_edge));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
